// File: rtl/framebuffer_serializer_buffered.sv
// Buffers AXI read beats in a small FIFO and serializes them into pixels chosen by a
// fetch-address stream, one pixel per cycle, with read-error tagging per pixel.
module framebuffer_serializer_buffered #(
  parameter int unsigned DATA_WIDTH      = 64,
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned ID_WIDTH        = 8,
  parameter int unsigned PIXEL_WIDTH     = 16,
  parameter int unsigned BEAT_FIFO_DEPTH = 4
) (
  input  logic                               aclk,
  input  logic                               reset,
  output logic                               m_frag_tvalid,
  input  logic                               m_frag_tready,
  output logic [PIXEL_WIDTH-1:0]             m_frag_tdata,
  output logic [ADDR_WIDTH-1:0]              m_frag_taddr,
  output logic                               m_frag_tlast,
  output logic                               m_frag_terr,
  input  logic                               s_fetch_tvalid,
  output logic                               s_fetch_tready,
  input  logic [ADDR_WIDTH-1:0]              s_fetch_taddr,
  input  logic                               s_fetch_tlast,
  input  logic [ID_WIDTH-1:0]                m_mem_axi_rid,
  input  logic [DATA_WIDTH-1:0]              m_mem_axi_rdata,
  input  logic [1:0]                         m_mem_axi_rresp,
  input  logic                               m_mem_axi_rlast,
  input  logic                               m_mem_axi_rvalid,
  output logic                               m_mem_axi_rready,
  output logic [$clog2(BEAT_FIFO_DEPTH):0]   fifo_level
);

  localparam int unsigned PPB   = DATA_WIDTH / PIXEL_WIDTH;
  localparam int unsigned SEL_W = $clog2(PPB);
  localparam int unsigned TAG_W = ADDR_WIDTH - SEL_W;
  localparam int unsigned PTR_W = $clog2(BEAT_FIFO_DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;
  localparam logic [LVL_W-1:0] DEPTH_L = LVL_W'(BEAT_FIFO_DEPTH);

  // Each entry is {beat data, error flag}.
  logic [DATA_WIDTH:0]   fifo_mem_q [BEAT_FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
  logic [LVL_W-1:0]      level_q, level_d;
  logic                  rready_q;

  logic [DATA_WIDTH-1:0] line_data_q;
  logic [TAG_W-1:0]      line_tag_q;
  logic                  line_err_q, line_valid_q;

  logic                   tvalid_q, tlast_q, terr_q;
  logic [PIXEL_WIDTH-1:0] tdata_q;
  logic [ADDR_WIDTH-1:0]  taddr_q;

  logic [TAG_W-1:0]       fetch_tag;
  logic [SEL_W-1:0]       sel;
  logic [DATA_WIDTH:0]    head;
  logic [DATA_WIDTH-1:0]  src_data;
  logic                   src_err, hit, fifo_empty, out_free;
  logic                   fetch_fire, push, pop;
  logic [PIXEL_WIDTH-1:0] pix;
  logic                   unused_inputs;

  assign unused_inputs = ^{m_mem_axi_rid, m_mem_axi_rlast, m_mem_axi_rresp[0]};

  assign fetch_tag = s_fetch_taddr[ADDR_WIDTH-1:SEL_W];
  assign sel       = s_fetch_taddr[SEL_W-1:0];
  assign head      = fifo_mem_q[rd_ptr_q];

  // Reset gates both ready outputs so no handshake completes in the reset cycle.
  always_comb begin
    hit            = line_valid_q && (fetch_tag == line_tag_q);
    fifo_empty     = (level_q == '0);
    out_free       = !tvalid_q || m_frag_tready;
    s_fetch_tready = !reset && s_fetch_tvalid && out_free && (hit || !fifo_empty);
    fetch_fire     = s_fetch_tvalid && s_fetch_tready;
    pop            = fetch_fire && !hit;
    push           = m_mem_axi_rvalid && m_mem_axi_rready;
    src_data       = hit ? line_data_q : head[DATA_WIDTH:1];
    src_err        = hit ? line_err_q : head[0];
    pix            = src_data[sel*PIXEL_WIDTH +: PIXEL_WIDTH];
    level_d        = level_q + {{(LVL_W-1){1'b0}}, push} - {{(LVL_W-1){1'b0}}, pop};
  end

  always_ff @(posedge aclk) begin
    if (push) begin
      fifo_mem_q[wr_ptr_q] <= {m_mem_axi_rdata, m_mem_axi_rresp[1]};
    end
  end

  always_ff @(posedge aclk) begin
    if (reset) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      rready_q     <= 1'b0;
      line_data_q  <= '0;
      line_tag_q   <= '0;
      line_err_q   <= 1'b0;
      line_valid_q <= 1'b0;
      tvalid_q     <= 1'b0;
      tdata_q      <= '0;
      taddr_q      <= '0;
      tlast_q      <= 1'b0;
      terr_q       <= 1'b0;
    end else begin
      level_q  <= level_d;
      rready_q <= (level_d < DEPTH_L);
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop) begin
        rd_ptr_q    <= rd_ptr_q + PTR_W'(1);
        line_data_q <= head[DATA_WIDTH:1];
        line_err_q  <= head[0];
        line_tag_q  <= fetch_tag;
      end
      if (fetch_fire) begin
        // Dropping the line at end of stream forces a fresh beat for the next stream.
        line_valid_q <= !s_fetch_tlast;
        tvalid_q     <= 1'b1;
        tdata_q      <= pix;
        taddr_q      <= s_fetch_taddr;
        tlast_q      <= s_fetch_tlast;
        terr_q       <= src_err;
      end else if (m_frag_tready) begin
        tvalid_q <= 1'b0;
      end
    end
  end

  assign m_mem_axi_rready = rready_q && !reset;
  assign fifo_level       = level_q;
  assign m_frag_tvalid    = tvalid_q;
  assign m_frag_tdata     = tdata_q;
  assign m_frag_taddr     = taddr_q;
  assign m_frag_tlast     = tlast_q;
  assign m_frag_terr      = terr_q;

endmodule

// File: tb/tb_framebuffer_serializer_buffered.sv
// Scoreboard bench: stimulus queues expected pixels, a negedge monitor checks fragments.
module tb_framebuffer_serializer_buffered;

  logic        aclk, reset;
  logic        m_frag_tvalid, m_frag_tready, m_frag_tlast, m_frag_terr;
  logic [15:0] m_frag_tdata;
  logic [31:0] m_frag_taddr;
  logic        s_fetch_tvalid, s_fetch_tready, s_fetch_tlast;
  logic [31:0] s_fetch_taddr;
  logic [7:0]  rid;
  logic [63:0] rdata;
  logic [1:0]  rresp;
  logic        rlast, rvalid, rready;
  logic [2:0]  fifo_level;

  framebuffer_serializer_buffered dut (
    .aclk             (aclk),
    .reset            (reset),
    .m_frag_tvalid    (m_frag_tvalid),
    .m_frag_tready    (m_frag_tready),
    .m_frag_tdata     (m_frag_tdata),
    .m_frag_taddr     (m_frag_taddr),
    .m_frag_tlast     (m_frag_tlast),
    .m_frag_terr      (m_frag_terr),
    .s_fetch_tvalid   (s_fetch_tvalid),
    .s_fetch_tready   (s_fetch_tready),
    .s_fetch_taddr    (s_fetch_taddr),
    .s_fetch_tlast    (s_fetch_tlast),
    .m_mem_axi_rid    (rid),
    .m_mem_axi_rdata  (rdata),
    .m_mem_axi_rresp  (rresp),
    .m_mem_axi_rlast  (rlast),
    .m_mem_axi_rvalid (rvalid),
    .m_mem_axi_rready (rready),
    .fifo_level       (fifo_level)
  );

  typedef struct packed {
    logic [15:0] data;
    logic [31:0] addr;
    logic        last;
    logic        err;
  } pix_t;

  pix_t exp_q[$];
  int   out_cyc[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;

  initial begin
    aclk = 1'b0;
    forever #5 aclk = ~aclk;
  end

  always @(posedge aclk) cyc <= cyc + 1;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endfunction

  // Monitor: a fragment handshake completes at the posedge following this negedge.
  always @(negedge aclk) begin
    if (!reset && m_frag_tvalid && m_frag_tready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_pixel actual=%0h required=none", m_frag_tdata);
      end else begin
        pix_t e;
        e = exp_q.pop_front();
        chk("tdata", 64'(m_frag_tdata), 64'(e.data));
        chk("taddr", 64'(m_frag_taddr), 64'(e.addr));
        chk("tlast", 64'(m_frag_tlast), 64'(e.last));
        chk("terr",  64'(m_frag_terr),  64'(e.err));
        out_cyc.push_back(cyc);
      end
    end
  end

  task automatic push_beat(input logic [63:0] d, input logic [1:0] r);
    int n = 0;
    rvalid = 1'b1;
    rdata  = d;
    rresp  = r;
    forever begin
      @(negedge aclk);
      if (rready) break;
      n++;
      if (n > 100) begin
        checks++;
        failures++;
        $display("FAIL beat_timeout actual=no_rready required=rready");
        break;
      end
    end
    @(posedge aclk);
    #1;
    rvalid = 1'b0;
  endtask

  task automatic fetch(input logic [31:0] a, input logic last, input logic [15:0] d,
                       input logic err);
    int n = 0;
    exp_q.push_back('{data: d, addr: a, last: last, err: err});
    s_fetch_tvalid = 1'b1;
    s_fetch_taddr  = a;
    s_fetch_tlast  = last;
    forever begin
      @(negedge aclk);
      if (s_fetch_tready) break;
      n++;
      if (n > 100) begin
        checks++;
        failures++;
        $display("FAIL fetch_timeout actual=no_tready required=tready addr=%0d", a);
        break;
      end
    end
    @(posedge aclk);
    #1;
    s_fetch_tvalid = 1'b0;
  endtask

  task automatic drain();
    repeat (4) @(posedge aclk);
    #1;
  endtask

  function automatic logic [63:0] beat3(input int i);
    logic [63:0] b;
    for (int j = 0; j < 4; j++) b[16*j +: 16] = 16'h0100 + 16'(4*i + j);
    return b;
  endfunction

  initial begin
    int first;
    reset = 1'b1;
    m_frag_tready = 1'b1;
    s_fetch_tvalid = 1'b0;
    s_fetch_taddr = '0;
    s_fetch_tlast = 1'b0;
    rid = '0;
    rdata = '0;
    rresp = '0;
    rlast = 1'b0;
    rvalid = 1'b0;
    repeat (3) @(posedge aclk);
    #1;
    chk("rst_tvalid", 64'(m_frag_tvalid), 0);
    chk("rst_tdata", 64'(m_frag_tdata), 0);
    chk("rst_taddr", 64'(m_frag_taddr), 0);
    chk("rst_tlast", 64'(m_frag_tlast), 0);
    chk("rst_terr", 64'(m_frag_terr), 0);
    chk("rst_rready", 64'(rready), 0);
    chk("rst_level", 64'(fifo_level), 0);
    chk("rst_fetch_tready", 64'(s_fetch_tready), 0);
    reset = 1'b0;

    // Two beats, eight sequential pixels back-to-back.
    push_beat(64'h0004_0003_0002_0001, 2'b00);
    push_beat(64'h0008_0007_0006_0005, 2'b00);
    first = out_cyc.size();
    for (int a = 0; a < 8; a++) fetch(32'(a), a == 7, 16'(a + 1), 1'b0);
    drain();
    chk("seq_level", 64'(fifo_level), 0);
    chk("seq_no_bubbles", 64'(out_cyc[first + 7] - out_cyc[first]), 7);

    // Same-tag reorder, then a fresh stream on the same address pops a new beat.
    push_beat(64'h0004_0003_0002_0001, 2'b00);
    push_beat(64'h0008_0007_0006_0005, 2'b00);
    fetch(32'd0, 1'b0, 16'h1, 1'b0);
    fetch(32'd2, 1'b0, 16'h3, 1'b0);
    fetch(32'd1, 1'b0, 16'h2, 1'b0);
    fetch(32'd3, 1'b1, 16'h4, 1'b0);
    fetch(32'd3, 1'b1, 16'h8, 1'b0);
    drain();
    chk("reorder_level", 64'(fifo_level), 0);

    // Fill the FIFO, then read 16 pixels.
    for (int i = 0; i < 4; i++) push_beat(beat3(i), 2'b00);
    chk("full_level", 64'(fifo_level), 4);
    chk("full_rready", 64'(rready), 0);
    @(posedge aclk);
    #1;
    chk("full_rready_hold", 64'(rready), 0);
    fetch(32'd0, 1'b0, 16'h0100, 1'b0);
    chk("rready_reassert", 64'(rready), 1);
    for (int a = 1; a < 16; a++) fetch(32'(a), a == 15, 16'h0100 + 16'(a), 1'b0);
    drain();
    chk("full_drain_level", 64'(fifo_level), 0);

    // Downstream back-pressure for 5 cycles.
    push_beat(64'h0044_0033_0022_0011, 2'b00);
    m_frag_tready = 1'b0;
    fetch(32'd0, 1'b0, 16'h0011, 1'b0);
    fork
      begin
        fetch(32'd1, 1'b0, 16'h0022, 1'b0);
        fetch(32'd2, 1'b0, 16'h0033, 1'b0);
        fetch(32'd3, 1'b1, 16'h0044, 1'b0);
      end
      begin
        repeat (5) begin
          @(negedge aclk);
          chk("stall_tvalid", 64'(m_frag_tvalid), 1);
          chk("stall_tdata", 64'(m_frag_tdata), 64'h11);
          chk("stall_taddr", 64'(m_frag_taddr), 0);
          chk("stall_fetch_tready", 64'(s_fetch_tready), 0);
        end
        @(posedge aclk);
        #1;
        m_frag_tready = 1'b1;
      end
    join
    drain();
    chk("stall_all_out", 64'(exp_q.size()), 0);

    // Error response propagates to exactly that beat's pixels.
    push_beat(64'h00A4_00A3_00A2_00A1, 2'b10);
    push_beat(64'h00B4_00B3_00B2_00B1, 2'b00);
    for (int a = 0; a < 4; a++) fetch(32'(a), 1'b0, 16'h00A1 + 16'(a), 1'b1);
    for (int a = 4; a < 8; a++) fetch(32'(a), a == 7, 16'h00B1 + 16'(a - 4), 1'b0);
    drain();

    // Reset mid-operation with two beats buffered and a pixel pending.
    for (int i = 0; i < 3; i++) push_beat(beat3(i + 4), 2'b00);
    m_frag_tready = 1'b0;
    fetch(32'd0, 1'b0, 16'h0110, 1'b0);
    chk("prerst_level", 64'(fifo_level), 2);
    chk("prerst_tvalid", 64'(m_frag_tvalid), 1);
    reset = 1'b1;
    @(posedge aclk);
    #1;
    reset = 1'b0;
    exp_q.delete();
    chk("midrst_tvalid", 64'(m_frag_tvalid), 0);
    chk("midrst_level", 64'(fifo_level), 0);
    m_frag_tready = 1'b1;
    s_fetch_tvalid = 1'b1;
    s_fetch_taddr = 32'd0;
    s_fetch_tlast = 1'b1;
    repeat (4) begin
      @(negedge aclk);
      chk("postrst_stall", 64'(s_fetch_tready), 0);
    end
    @(posedge aclk);
    #1;
    push_beat(64'h0D04_0D03_0D02_0D01, 2'b00);
    fetch(32'd0, 1'b1, 16'h0D01, 1'b0);
    drain();
    chk("final_queue_empty", 64'(exp_q.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/framebuffer_serializer_buffered.md
Name: framebuffer_serializer_buffered

Overview:
- Successor to the single-line framebuffer serializer, sitting between the AXI read data channel and the framebuffer fragment pipeline.
- Buffers incoming memory beats in a parametrised FIFO, so memory latency and bursts are decoupled from the fetch stream.
- Serializes each beat into pixels selected by the fetch address, at 1 pixel/cycle sustained.
- Adds propagation of read-error responses, and a fill-level output for the upstream request generator.

Parameters:
- DATA_WIDTH, 64, AXI read data width in bits; multiple of PIXEL_WIDTH, ratio a power of two.
- ADDR_WIDTH, 32, pixel-index address width.
- ID_WIDTH, 8, AXI ID width; the ID is ignored.
- PIXEL_WIDTH, 16, pixel width in bits.
- BEAT_FIFO_DEPTH, 4, memory beat buffer depth; power of two, ≥2.
- Derived: PPB = DATA_WIDTH/PIXEL_WIDTH; SEL_W = log2(PPB); TAG_W = ADDR_WIDTH-SEL_W.

Ports:
- aclk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- m_frag_tvalid  out  1  fragment valid.
- m_frag_tready  in  1  fragment ready.
- m_frag_tdata  out  PIXEL_WIDTH  pixel.
- m_frag_taddr  out  ADDR_WIDTH  pixel address (copy of fetch address).
- m_frag_tlast  out  1  last pixel of stream.
- m_frag_terr  out  1  pixel comes from a beat with rresp[1]=1 (SLVERR/DECERR).
- s_fetch_tvalid  in  1  fetch address valid.
- s_fetch_tready  out  1  fetch address accepted.
- s_fetch_taddr  in  ADDR_WIDTH  pixel address.
- s_fetch_tlast  in  1  last fetch of stream.
- m_mem_axi_rid  in  ID_WIDTH  unused.
- m_mem_axi_rdata  in  DATA_WIDTH  beat data.
- m_mem_axi_rresp  in  2  beat response.
- m_mem_axi_rlast  in  1  unused (beats are treated individually).
- m_mem_axi_rvalid  in  1  beat valid.
- m_mem_axi_rready  out  1  beat accepted.
- fifo_level  out  log2(BEAT_FIFO_DEPTH)+1  current number of buffered beats.

Behaviour:
- Reset values:
  - Outputs: m_frag_tvalid=0, m_frag_tlast=0, m_frag_terr=0, m_frag_tdata=0, m_frag_taddr=0, m_mem_axi_rready=0, fifo_level=0, s_fetch_tready=0.
  - Internal: line_valid=0, FIFO emptied.
  - Reset mid-operation discards the buffered beats and any pending output pixel; it issues no handshake in the reset cycle.
- Beat FIFO:
  - m_mem_axi_rready is registered: in the cycle after reset release and after, it is 1 iff the next-cycle level < BEAT_FIFO_DEPTH.
  - A push stores {rdata, rresp[1]} on rvalid&&rready.
  - Simultaneous push and pop keeps the level unchanged.
  - Never overflows: rready is already low when the FIFO is full, and a push at level DEPTH-1 with no pop drops rready next cycle.
- Line register:
  - Holds line_data, line_tag (TAG_W bits), line_err, line_valid.
  - hit = line_valid && (s_fetch_taddr[ADDR_WIDTH-1:SEL_W] == line_tag).
  - miss_ok = !hit && fifo not empty.
- Output stage: out_free = !m_frag_tvalid || m_frag_tready.
- s_fetch_tready = s_fetch_tvalid && out_free && (hit || miss_ok). This is combinational from registered state and the fetch inputs.
- On a fetch handshake (registered, 1-cycle latency fetch→frag):
  - Source: line = hit ? current line : FIFO head. On a miss the head is popped into the line register, line_tag is set to the fetch tag, and line_valid=1.
  - m_frag_tdata = source[PIXEL_WIDTH*sel +: PIXEL_WIDTH], where sel = s_fetch_taddr[SEL_W-1:0].
  - m_frag_taddr = s_fetch_taddr; m_frag_tlast = s_fetch_tlast; m_frag_terr = source error bit; m_frag_tvalid=1.
  - If s_fetch_tlast: line_valid=0 next cycle, so the next stream always pops a fresh beat.
- If there is no fetch handshake and m_frag_tready=1: m_frag_tvalid=0.
- If m_frag_tvalid=1 and m_frag_tready=0: all m_frag_* outputs hold stable.
- Miss with an empty FIFO: the fetch stalls (tready=0) until a beat is pushed. The earliest acceptance is the cycle after the push.
- Non-sequential fetch addresses: every tag change pops exactly one beat. Memory must supply one beat per distinct consecutive tag.
- Throughput: 1 pixel/cycle while tready is held high and the FIFO is non-empty at each tag change.

Test Plan:
- Defaults; beats 0x0004_0003_0002_0001 and 0x0008_0007_0006_0005 pushed; fetch addresses 0..7 back-to-back, tready=1 -> tdata 1..8 on consecutive cycles, taddr 0..7, fifo_level returns to 0, no bubbles.
- Fetch addresses 0,2,1,3 (same tag) then tlast on 3 -> tdata 1,3,2,4; tlast only on the 4th pixel; a following fetch address 3 pops a new beat instead of hitting.
- Push 4 beats with no fetch -> rready low once level=4; fifo_level=4. Then fetch 16 pixels with tready=1 -> rready re-asserts after the first pop; all 16 pixels correct.
- m_frag_tready held 0 for 5 cycles mid-stream -> tvalid/tdata/taddr stable; s_fetch_tready=0; no pixel lost or duplicated after release.
- Beat with rresp=2'b10 -> its 4 pixels carry m_frag_terr=1; pixels of the next beat (rresp=0) carry terr=0.
- Assert reset for 1 cycle with level=2 and tvalid=1 -> next cycle tvalid=0, fifo_level=0; a fetch after reset stalls until a new beat arrives.
